// File: rtl/alu_pipe_hs.sv
// -----------------------------------------------------------------------------
// alu_pipe_hs
//   Handshaked ALU. Logical (MODE=0) and arithmetic (MODE=1) operations over
//   WIDTH-bit operands. Single-cycle ops register their result on the accept
//   edge. The two multiply ops run an iterative shift-add over WIDTH+1 cycles.
//   Only one transaction is in flight at a time.
//
// Optional build macro:
//   ALU_PARITY_EN  adds output RES_PAR, the even parity (XOR reduction) of
//                  RES. It is registered alongside RES.
//
// Ports:
//   CLK       clock, rising edge
//   RST_N     asynchronous active-low reset
//   CE        clock enable; low freezes all state and outputs
//   IN_VLD    input transaction valid
//   IN_RDY    block can accept a transaction
//   OP_VALID  operand qualifiers (bit0 = OPA valid, bit1 = OPB valid)
//   MODE      1 = arithmetic, 0 = logical
//   CMD       operation code
//   OPA/OPB   operands
//   CIN       carry/borrow in
//   RES       2*WIDTH result
//   COUT, OFLOW, G, E, L, ERR   flags, registered with RES
//   OUT_VLD   result valid
//   OUT_RDY   consumer accepts result
//   RES_PAR   (ALU_PARITY_EN only) parity of RES
// -----------------------------------------------------------------------------
module alu_pipe_hs #(
    parameter int WIDTH     = 8,
    parameter int CMD_WIDTH = 4
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   CE,
    input  logic                   IN_VLD,
    output logic                   IN_RDY,
    input  logic [1:0]             OP_VALID,
    input  logic                   MODE,
    input  logic [CMD_WIDTH-1:0]   CMD,
    input  logic [WIDTH-1:0]       OPA,
    input  logic [WIDTH-1:0]       OPB,
    input  logic                   CIN,
    output logic [2*WIDTH-1:0]     RES,
    output logic                   COUT,
    output logic                   OFLOW,
    output logic                   G,
    output logic                   E,
    output logic                   L,
    output logic                   ERR,
    output logic                   OUT_VLD,
    input  logic                   OUT_RDY
`ifdef ALU_PARITY_EN
    ,
    output logic                   RES_PAR
`endif
);

    localparam int W2   = 2 * WIDTH;
    localparam int PW   = 2 * WIDTH + 1;
    localparam int SHW  = $clog2(WIDTH);
    localparam int CNTW = $clog2(WIDTH + 1);

    localparam logic [CNTW-1:0]  MUL_LAST = CNTW'(WIDTH);
    localparam logic [WIDTH:0]   ONE_X    = (WIDTH + 1)'(1);
    localparam logic [SHW:0]     WID_X    = (SHW + 1)'(WIDTH);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MUL  = 1'b1;

    // Arithmetic command codes (MODE=1)
    localparam logic [CMD_WIDTH-1:0] A_ADD  = CMD_WIDTH'(0);
    localparam logic [CMD_WIDTH-1:0] A_SUB  = CMD_WIDTH'(1);
    localparam logic [CMD_WIDTH-1:0] A_ADDC = CMD_WIDTH'(2);
    localparam logic [CMD_WIDTH-1:0] A_SUBC = CMD_WIDTH'(3);
    localparam logic [CMD_WIDTH-1:0] A_INCA = CMD_WIDTH'(4);
    localparam logic [CMD_WIDTH-1:0] A_DECA = CMD_WIDTH'(5);
    localparam logic [CMD_WIDTH-1:0] A_INCB = CMD_WIDTH'(6);
    localparam logic [CMD_WIDTH-1:0] A_DECB = CMD_WIDTH'(7);
    localparam logic [CMD_WIDTH-1:0] A_CMP  = CMD_WIDTH'(8);
    localparam logic [CMD_WIDTH-1:0] A_MULI = CMD_WIDTH'(9);
    localparam logic [CMD_WIDTH-1:0] A_MULS = CMD_WIDTH'(10);
    localparam logic [CMD_WIDTH-1:0] A_SADD = CMD_WIDTH'(11);
    localparam logic [CMD_WIDTH-1:0] A_SSUB = CMD_WIDTH'(12);

    // Logical command codes (MODE=0)
    localparam logic [CMD_WIDTH-1:0] L_AND  = CMD_WIDTH'(0);
    localparam logic [CMD_WIDTH-1:0] L_NAND = CMD_WIDTH'(1);
    localparam logic [CMD_WIDTH-1:0] L_OR   = CMD_WIDTH'(2);
    localparam logic [CMD_WIDTH-1:0] L_NOR  = CMD_WIDTH'(3);
    localparam logic [CMD_WIDTH-1:0] L_XOR  = CMD_WIDTH'(4);
    localparam logic [CMD_WIDTH-1:0] L_XNOR = CMD_WIDTH'(5);
    localparam logic [CMD_WIDTH-1:0] L_NOTA = CMD_WIDTH'(6);
    localparam logic [CMD_WIDTH-1:0] L_NOTB = CMD_WIDTH'(7);
    localparam logic [CMD_WIDTH-1:0] L_SRA1 = CMD_WIDTH'(8);
    localparam logic [CMD_WIDTH-1:0] L_SLA1 = CMD_WIDTH'(9);
    localparam logic [CMD_WIDTH-1:0] L_SRB1 = CMD_WIDTH'(10);
    localparam logic [CMD_WIDTH-1:0] L_SLB1 = CMD_WIDTH'(11);
    localparam logic [CMD_WIDTH-1:0] L_ROL  = CMD_WIDTH'(12);
    localparam logic [CMD_WIDTH-1:0] L_ROR  = CMD_WIDTH'(13);

    function automatic logic [W2-1:0] zx1(input logic [WIDTH:0] v);
        return {{(WIDTH - 1){1'b0}}, v};
    endfunction

    function automatic logic [W2-1:0] zxw(input logic [WIDTH-1:0] v);
        return {{WIDTH{1'b0}}, v};
    endfunction

    function automatic logic [W2-1:0] sxw(input logic [WIDTH-1:0] v);
        return {{WIDTH{v[WIDTH-1]}}, v};
    endfunction

    // Control state
    logic [0:0]       r_state;
    logic [CNTW-1:0]  r_cnt;
    logic             r_live;
    logic             r_out_vld;

    // Result and multiplier datapath registers
    logic [W2-1:0]    r_res;
    logic             r_cout, r_oflow, r_g, r_e, r_l, r_err;
    logic [PW-1:0]    r_acc;
    logic [PW-1:0]    r_mcand;
    logic [WIDTH:0]   r_mplr;

    // Operand-derived intermediates
    logic [WIDTH:0]   w_a_ext, w_b_ext;
    logic [WIDTH:0]   w_sum, w_sumc, w_diff, w_diffc;
    logic [WIDTH:0]   w_inca, w_deca, w_incb, w_decb;
    logic [WIDTH-1:0] w_ssum, w_sdiff, w_rol, w_ror;
    logic [SHW-1:0]   w_sh;
    logic [SHW:0]     w_rsh;
    logic             w_rng;
    logic             w_sadd_ov, w_ssub_ov;

    // Decoded single-cycle result
    logic [W2-1:0]    w_r;
    logic             w_c, w_o, w_g, w_e, w_l, w_rerr;
    logic [1:0]       w_need;
    logic             w_def, w_mul;

    logic             w_accept, w_mul_last, w_load;
    logic [PW-1:0]    w_acc_nxt;
    logic [W2-1:0]    w_ld_res;
    logic             w_ld_c, w_ld_o, w_ld_g, w_ld_e, w_ld_l, w_ld_err;
    logic [WIDTH:0]   w_mcand0, w_mplr0;

    assign w_a_ext = {1'b0, OPA};
    assign w_b_ext = {1'b0, OPB};
    assign w_sum   = w_a_ext + w_b_ext;
    assign w_sumc  = w_a_ext + w_b_ext + {{WIDTH{1'b0}}, CIN};
    assign w_diff  = w_a_ext - w_b_ext;
    assign w_diffc = w_a_ext - w_b_ext - {{WIDTH{1'b0}}, CIN};
    assign w_inca  = w_a_ext + ONE_X;
    assign w_deca  = w_a_ext - ONE_X;
    assign w_incb  = w_b_ext + ONE_X;
    assign w_decb  = w_b_ext - ONE_X;
    assign w_ssum  = OPA + OPB;
    assign w_sdiff = OPA - OPB;

    // Signed overflow: operands agree in sign (add) or differ (sub) and the
    // result sign differs from A.
    assign w_sadd_ov = (OPA[WIDTH-1] == OPB[WIDTH-1]) && (w_ssum[WIDTH-1]  != OPA[WIDTH-1]);
    assign w_ssub_ov = (OPA[WIDTH-1] != OPB[WIDTH-1]) && (w_sdiff[WIDTH-1] != OPA[WIDTH-1]);

    // Rotate by the masked amount; a zero amount shifts the wrap term by
    // WIDTH, which clears it.
    assign w_sh  = OPB[SHW-1:0];
    assign w_rsh = WID_X - {1'b0, w_sh};
    assign w_rol = (OPA << w_sh) | (OPA >> w_rsh);
    assign w_ror = (OPA >> w_sh) | (OPA << w_rsh);
    assign w_rng = |(OPB >> SHW);

    always_comb begin
        w_need = 2'b11;
        w_def  = 1'b1;
        w_mul  = 1'b0;
        w_r    = '0;
        w_c    = 1'b0;
        w_o    = 1'b0;
        w_g    = 1'b0;
        w_e    = 1'b0;
        w_l    = 1'b0;
        w_rerr = 1'b0;
        if (MODE) begin
            case (CMD)
                A_ADD:  begin w_r = zx1(w_sum);   w_c = w_sum[WIDTH]; end
                A_SUB:  begin w_r = zx1(w_diff);  w_o = (OPA < OPB); end
                A_ADDC: begin w_r = zx1(w_sumc);  w_c = w_sumc[WIDTH]; end
                A_SUBC: begin w_r = zx1(w_diffc); w_o = w_diffc[WIDTH]; end
                A_INCA: begin w_need = 2'b01; w_r = zx1(w_inca); w_c = w_inca[WIDTH]; end
                A_DECA: begin w_need = 2'b01; w_r = zx1(w_deca); w_o = (OPA == '0); end
                A_INCB: begin w_need = 2'b10; w_r = zx1(w_incb); w_c = w_incb[WIDTH]; end
                A_DECB: begin w_need = 2'b10; w_r = zx1(w_decb); w_o = (OPB == '0); end
                A_CMP:  begin w_g = (OPA > OPB); w_e = (OPA == OPB); w_l = (OPA < OPB); end
                A_MULI, A_MULS: w_mul = 1'b1;
                A_SADD: begin w_r = sxw(w_ssum);  w_o = w_sadd_ov; w_c = w_sum[WIDTH]; end
                A_SSUB: begin w_r = sxw(w_sdiff); w_o = w_ssub_ov; end
                default: w_def = 1'b0;
            endcase
        end else begin
            case (CMD)
                L_AND:  w_r = zxw(OPA & OPB);
                L_NAND: w_r = zxw(~(OPA & OPB));
                L_OR:   w_r = zxw(OPA | OPB);
                L_NOR:  w_r = zxw(~(OPA | OPB));
                L_XOR:  w_r = zxw(OPA ^ OPB);
                L_XNOR: w_r = zxw(~(OPA ^ OPB));
                L_NOTA: begin w_need = 2'b01; w_r = zxw(~OPA); end
                L_NOTB: begin w_need = 2'b10; w_r = zxw(~OPB); end
                L_SRA1: begin w_need = 2'b01; w_r = zxw(OPA >> 1); end
                L_SLA1: begin w_need = 2'b01; w_r = zxw(OPA << 1); end
                L_SRB1: begin w_need = 2'b10; w_r = zxw(OPB >> 1); end
                L_SLB1: begin w_need = 2'b10; w_r = zxw(OPB << 1); end
                L_ROL:  begin w_r = zxw(w_rol); w_rerr = w_rng; end
                L_ROR:  begin w_r = zxw(w_ror); w_rerr = w_rng; end
                default: w_def = 1'b0;
            endcase
        end
        // Missing operands or an unknown code turn into a plain error result.
        if (!w_def || ((OP_VALID & w_need) != w_need)) begin
            w_r    = '0;
            w_c    = 1'b0;
            w_o    = 1'b0;
            w_g    = 1'b0;
            w_e    = 1'b0;
            w_l    = 1'b0;
            w_rerr = 1'b1;
            w_mul  = 1'b0;
        end
    end

    // MUL_INC multiplies (A+1)*(B+1); MUL_SHL multiplies (A<<1)*B with the
    // shifted A kept at WIDTH+1 bits.
    assign w_mcand0 = (CMD == A_MULI) ? w_inca : {OPA, 1'b0};
    assign w_mplr0  = (CMD == A_MULI) ? w_incb : w_b_ext;
    assign w_acc_nxt = r_acc + (r_mplr[0] ? r_mcand : '0);

    assign IN_RDY     = r_live && CE && (r_state != S_MUL) && (!r_out_vld || OUT_RDY);
    assign w_accept   = IN_VLD && IN_RDY;
    assign w_mul_last = (r_state == S_MUL) && (r_cnt == MUL_LAST);
    assign w_load     = CE && ((w_accept && !w_mul) || w_mul_last);

    assign w_ld_res = (r_state == S_MUL) ? w_acc_nxt[W2-1:0] : w_r;
    assign w_ld_c   = (r_state == S_MUL) ? w_acc_nxt[W2]     : w_c;
    assign w_ld_o   = (r_state == S_MUL) ? 1'b0 : w_o;
    assign w_ld_g   = (r_state == S_MUL) ? 1'b0 : w_g;
    assign w_ld_e   = (r_state == S_MUL) ? 1'b0 : w_e;
    assign w_ld_l   = (r_state == S_MUL) ? 1'b0 : w_l;
    assign w_ld_err = (r_state == S_MUL) ? 1'b0 : w_rerr;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_live    <= 1'b0;
            r_out_vld <= 1'b0;
            r_res     <= '0;
            r_cout    <= 1'b0;
            r_oflow   <= 1'b0;
            r_g       <= 1'b0;
            r_e       <= 1'b0;
            r_l       <= 1'b0;
            r_err     <= 1'b0;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplr    <= '0;
        end else if (CE) begin
            // r_live holds IN_RDY low until the first enabled edge after reset.
            r_live <= 1'b1;

            if (w_load) begin
                r_res   <= w_ld_res;
                r_cout  <= w_ld_c;
                r_oflow <= w_ld_o;
                r_g     <= w_ld_g;
                r_e     <= w_ld_e;
                r_l     <= w_ld_l;
                r_err   <= w_ld_err;
            end

            if (w_load) begin
                r_out_vld <= 1'b1;
            end else if (OUT_RDY) begin
                r_out_vld <= 1'b0;
            end

            if (w_accept && w_mul) begin
                r_state <= S_MUL;
                r_cnt   <= '0;
                r_acc   <= '0;
                r_mcand <= {{WIDTH{1'b0}}, w_mcand0};
                r_mplr  <= w_mplr0;
            end else if (r_state == S_MUL) begin
                r_acc   <= w_acc_nxt;
                r_mcand <= r_mcand << 1;
                r_mplr  <= r_mplr >> 1;
                if (w_mul_last) begin
                    r_state <= S_IDLE;
                end else begin
                    r_cnt <= r_cnt + CNTW'(1);
                end
            end
        end
    end

    assign RES     = r_res;
    assign COUT    = r_cout;
    assign OFLOW   = r_oflow;
    assign G       = r_g;
    assign E       = r_e;
    assign L       = r_l;
    assign ERR     = r_err;
    assign OUT_VLD = r_out_vld;

`ifdef ALU_PARITY_EN
    logic r_res_par;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_res_par <= 1'b0;
        end else if (w_load) begin
            r_res_par <= ^w_ld_res;
        end
    end

    assign RES_PAR = r_res_par;
`endif

endmodule

// File: tb/tb_alu_pipe_hs.sv
module tb_alu_pipe_hs;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        ce = 1'b1;
    logic        in_vld = 1'b0;
    logic        in_rdy;
    logic [1:0]  op_valid = 2'b11;
    logic        mode = 1'b1;
    logic [3:0]  cmd = 4'd0;
    logic [7:0]  opa = 8'h00;
    logic [7:0]  opb = 8'h00;
    logic        cin = 1'b0;
    logic [15:0] res;
    logic        cout, oflow, g, e, l, err;
    logic        out_vld;
    logic        out_rdy = 1'b1;

    logic [22:0] obs;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign obs = {out_vld, res, cout, oflow, g, e, l, err};

    alu_pipe_hs #(.WIDTH(8), .CMD_WIDTH(4)) dut (
        .CLK      (clk),
        .RST_N    (rst_n),
        .CE       (ce),
        .IN_VLD   (in_vld),
        .IN_RDY   (in_rdy),
        .OP_VALID (op_valid),
        .MODE     (mode),
        .CMD      (cmd),
        .OPA      (opa),
        .OPB      (opb),
        .CIN      (cin),
        .RES      (res),
        .COUT     (cout),
        .OFLOW    (oflow),
        .G        (g),
        .E        (e),
        .L        (l),
        .ERR      (err),
        .OUT_VLD  (out_vld),
        .OUT_RDY  (out_rdy)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic m, input logic [3:0] c, input logic [1:0] ov,
                         input logic [7:0] a, input logic [7:0] b, input logic ci);
        mode = m; cmd = c; op_valid = ov; opa = a; opb = b; cin = ci;
        in_vld = 1'b1;
    endtask

    // Present a transaction for one edge; the block must be ready.
    task automatic issue(input logic m, input logic [3:0] c, input logic [1:0] ov,
                         input logic [7:0] a, input logic [7:0] b, input logic ci);
        drive(m, c, ov, a, b, ci);
        step;
        in_vld = 1'b0;
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        #1;
        if ({in_rdy, obs} !== 24'h0) begin
            $display("FAIL reset_state: got %h want %h", {in_rdy, obs}, 24'h0); n_fail++;
        end
        n_cmp++;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        #1;
        if (in_rdy !== 1'b0) begin
            $display("FAIL rdy_before_edge: got %b want 0", in_rdy); n_fail++;
        end
        n_cmp++;
        step;
        if (in_rdy !== 1'b1) begin
            $display("FAIL rdy_after_release: got %b want 1", in_rdy); n_fail++;
        end
        n_cmp++;
    endtask

    task automatic test_arith;
        issue(1'b1, 4'd0, 2'b11, 8'hFF, 8'h01, 1'b0);
        if (obs !== {1'b1, 16'h0100, 6'b100000}) begin
            $display("FAIL add_ff_01: got %h want %h", obs, {1'b1, 16'h0100, 6'b100000}); n_fail++;
        end
        n_cmp++;
        step; // OUT_RDY=1, nothing new: result drains, RES holds
        if ({out_vld, res} !== {1'b0, 16'h0100}) begin
            $display("FAIL drain: got %h want %h", {out_vld, res}, {1'b0, 16'h0100}); n_fail++;
        end
        n_cmp++;
        issue(1'b1, 4'd2, 2'b11, 8'h10, 8'h20, 1'b1);
        if (obs !== {1'b1, 16'h0031, 6'b000000}) begin
            $display("FAIL addc: got %h want %h", obs, {1'b1, 16'h0031, 6'b000000}); n_fail++;
        end
        n_cmp++;
        issue(1'b1, 4'd1, 2'b11, 8'h05, 8'h03, 1'b0);
        if (obs !== {1'b1, 16'h0002, 6'b000000}) begin
            $display("FAIL sub: got %h want %h", obs, {1'b1, 16'h0002, 6'b000000}); n_fail++;
        end
        n_cmp++;
        issue(1'b1, 4'd1, 2'b11, 8'h03, 8'h05, 1'b0);
        if (oflow !== 1'b1) begin
            $display("FAIL sub_borrow: got %b want 1", oflow); n_fail++;
        end
        n_cmp++;
        issue(1'b1, 4'd4, 2'b01, 8'hFF, 8'h00, 1'b0);
        if (obs !== {1'b1, 16'h0100, 6'b100000}) begin
            $display("FAIL inc_a: got %h want %h", obs, {1'b1, 16'h0100, 6'b100000}); n_fail++;
        end
        n_cmp++;
        issue(1'b1, 4'd7, 2'b10, 8'h00, 8'h00, 1'b0);
        if (oflow !== 1'b1) begin
            $display("FAIL dec_b_zero: got %b want 1", oflow); n_fail++;
        end
        n_cmp++;
        issue(1'b1, 4'd8, 2'b11, 8'h03, 8'h05, 1'b0);
        if (obs !== {1'b1, 16'h0000, 6'b000010}) begin
            $display("FAIL cmp_lt: got %h want %h", obs, {1'b1, 16'h0000, 6'b000010}); n_fail++;
        end
        n_cmp++;
        issue(1'b1, 4'd8, 2'b11, 8'h44, 8'h44, 1'b0);
        if (obs !== {1'b1, 16'h0000, 6'b000100}) begin
            $display("FAIL cmp_eq: got %h want %h", obs, {1'b1, 16'h0000, 6'b000100}); n_fail++;
        end
        n_cmp++;
        issue(1'b1, 4'd11, 2'b11, 8'h7F, 8'h01, 1'b0);
        if (obs !== {1'b1, 16'hFF80, 6'b010000}) begin
            $display("FAIL sadd_ovf: got %h want %h", obs, {1'b1, 16'hFF80, 6'b010000}); n_fail++;
        end
        n_cmp++;
        issue(1'b1, 4'd12, 2'b11, 8'h80, 8'h01, 1'b0);
        if (obs !== {1'b1, 16'h007F, 6'b010000}) begin
            $display("FAIL ssub_ovf: got %h want %h", obs, {1'b1, 16'h007F, 6'b010000}); n_fail++;
        end
        n_cmp++;
    endtask

    task automatic test_logic;
        logic [3:0]  cmds [5] = '{4'd0, 4'd1, 4'd7, 4'd9, 4'd10};
        logic [1:0]  ovs  [5] = '{2'b11, 2'b11, 2'b10, 2'b01, 2'b10};
        logic [7:0]  as   [5] = '{8'hF0, 8'hF0, 8'h00, 8'h81, 8'h00};
        logic [7:0]  bs   [5] = '{8'h3C, 8'h3C, 8'h0F, 8'h00, 8'h81};
        logic [15:0] exps [5] = '{16'h0030, 16'h00CF, 16'h00F0, 16'h0002, 16'h0040};
        for (int i = 0; i < 5; i++) begin
            issue(1'b0, cmds[i], ovs[i], as[i], bs[i], 1'b0);
            if (obs !== {1'b1, exps[i], 6'b000000}) begin
                $display("FAIL logic_%0d: got %h want %h", i, obs, {1'b1, exps[i], 6'b000000}); n_fail++;
            end
            n_cmp++;
        end
    endtask

    task automatic test_rotate;
        issue(1'b0, 4'd12, 2'b11, 8'h81, 8'h01, 1'b0);
        if (obs !== {1'b1, 16'h0003, 6'b000000}) begin
            $display("FAIL rol_1: got %h want %h", obs, {1'b1, 16'h0003, 6'b000000}); n_fail++;
        end
        n_cmp++;
        issue(1'b0, 4'd12, 2'b11, 8'h81, 8'h09, 1'b0);
        if (obs !== {1'b1, 16'h0003, 6'b000001}) begin
            $display("FAIL rol_range: got %h want %h", obs, {1'b1, 16'h0003, 6'b000001}); n_fail++;
        end
        n_cmp++;
        issue(1'b0, 4'd13, 2'b11, 8'h81, 8'h01, 1'b0);
        if (obs !== {1'b1, 16'h00C0, 6'b000000}) begin
            $display("FAIL ror_1: got %h want %h", obs, {1'b1, 16'h00C0, 6'b000000}); n_fail++;
        end
        n_cmp++;
    endtask

    task automatic test_errors;
        logic [3:0] cmds [4] = '{4'd0, 4'd13, 4'd9, 4'd4};
        logic [1:0] ovs  [4] = '{2'b01, 2'b11, 2'b10, 2'b10};
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, cmds[i], ovs[i], 8'h12, 8'h34, 1'b0);
            if (obs !== {1'b1, 16'h0000, 6'b000001}) begin
                $display("FAIL err_%0d: got %h want %h", i, obs, {1'b1, 16'h0000, 6'b000001}); n_fail++;
            end
            n_cmp++;
        end
    endtask

    task automatic test_mul;
        logic [3:0]  cmds [3] = '{4'd9, 4'd9, 4'd10};
        logic [7:0]  as   [3] = '{8'h03, 8'hFF, 8'h81};
        logic [7:0]  bs   [3] = '{8'h03, 8'hFF, 8'h02};
        logic [15:0] exps [3] = '{16'h0010, 16'h0000, 16'h0204};
        logic [5:0]  flg  [3] = '{6'b000000, 6'b100000, 6'b000000};
        int  cyc;
        bit  rdy_lo;
        for (int i = 0; i < 3; i++) begin
            issue(1'b1, cmds[i], 2'b11, as[i], bs[i], 1'b0);
            cyc = 0;
            rdy_lo = 1'b1;
            while (out_vld !== 1'b1 && cyc < 20) begin
                if (in_rdy !== 1'b0) rdy_lo = 1'b0;
                step;
                cyc++;
            end
            // accept edge is edge 1; result lands on edge 10, nine edges later
            if (cyc != 9) begin
                $display("FAIL mul_lat_%0d: got %0d want 9", i, cyc); n_fail++;
            end
            n_cmp++;
            if (!rdy_lo) begin
                $display("FAIL mul_rdy_%0d: got ready during multiply want not ready", i); n_fail++;
            end
            n_cmp++;
            if (obs !== {1'b1, exps[i], flg[i]}) begin
                $display("FAIL mul_res_%0d: got %h want %h", i, obs, {1'b1, exps[i], flg[i]}); n_fail++;
            end
            n_cmp++;
        end
    endtask

    task automatic test_backpressure;
        step;
        out_rdy = 1'b0;
        issue(1'b1, 4'd0, 2'b11, 8'h01, 8'h02, 1'b0);
        drive(1'b0, 4'd4, 2'b11, 8'h0F, 8'hFF, 1'b0);
        if (in_rdy !== 1'b0) begin
            $display("FAIL bp_rdy_low: got %b want 0", in_rdy); n_fail++;
        end
        n_cmp++;
        step;
        step;
        if (obs !== {1'b1, 16'h0003, 6'b000000}) begin
            $display("FAIL bp_hold: got %h want %h", obs, {1'b1, 16'h0003, 6'b000000}); n_fail++;
        end
        n_cmp++;
        out_rdy = 1'b1;
        #1;
        if (in_rdy !== 1'b1) begin
            $display("FAIL bp_rdy_high: got %b want 1", in_rdy); n_fail++;
        end
        n_cmp++;
        step;
        in_vld = 1'b0;
        if (obs !== {1'b1, 16'h00F0, 6'b000000}) begin
            $display("FAIL bp_replace: got %h want %h", obs, {1'b1, 16'h00F0, 6'b000000}); n_fail++;
        end
        n_cmp++;
    endtask

    task automatic test_ce;
        int cyc;
        issue(1'b1, 4'd9, 2'b11, 8'h01, 8'h01, 1'b0);
        ce = 1'b0;
        repeat (3) step;
        if (in_rdy !== 1'b0 || out_vld !== 1'b0) begin
            $display("FAIL ce_stall: got rdy=%b vld=%b want 0 0", in_rdy, out_vld); n_fail++;
        end
        n_cmp++;
        ce = 1'b1;
        cyc = 0;
        while (out_vld !== 1'b1 && cyc < 20) begin
            step;
            cyc++;
        end
        if (cyc != 9 || res !== 16'h0004) begin
            $display("FAIL ce_mul: got cyc=%0d res=%h want cyc=9 res=0004", cyc, res); n_fail++;
        end
        n_cmp++;
        ce = 1'b0;
        step;
        if (out_vld !== 1'b1) begin
            $display("FAIL ce_hold_vld: got %b want 1", out_vld); n_fail++;
        end
        n_cmp++;
        ce = 1'b1;
        step;
        if (out_vld !== 1'b0) begin
            $display("FAIL ce_resume_drain: got %b want 0", out_vld); n_fail++;
        end
        n_cmp++;
    endtask

    task automatic test_reset_mid_mul;
        bit saw_vld;
        issue(1'b1, 4'd0, 2'b11, 8'h01, 8'h02, 1'b0);
        issue(1'b1, 4'd9, 2'b11, 8'h03, 8'h03, 1'b0);
        repeat (4) step;
        #2 rst_n = 1'b0;
        #1;
        if ({in_rdy, obs} !== 24'h0) begin
            $display("FAIL mid_mul_reset: got %h want %h", {in_rdy, obs}, 24'h0); n_fail++;
        end
        n_cmp++;
        repeat (4) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        step;
        if (in_rdy !== 1'b1) begin
            $display("FAIL mid_mul_rdy: got %b want 1", in_rdy); n_fail++;
        end
        n_cmp++;
        saw_vld = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (out_vld !== 1'b0) saw_vld = 1'b1;
            step;
        end
        if (saw_vld) begin
            $display("FAIL mid_mul_no_vld: got valid after aborted multiply want none"); n_fail++;
        end
        n_cmp++;
    endtask

    initial begin
        test_reset;
        test_arith;
        test_logic;
        test_rotate;
        test_errors;
        test_mul;
        test_backpressure;
        test_ce;
        test_reset_mid_mul;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_pipe_hs.md
Name: alu_pipe_hs

Overview:
- Parametrised, handshaked successor ALU: arithmetic (MODE=1) and logical (MODE=0) operations over WIDTH-bit operands.
- valid/ready on both input and output sides; result register holds under backpressure.
- Single-cycle ops: one-cycle latency. Multiplies: iterative shift-add over WIDTH+1 cycles.
- Sits between an operand-issue stage and a result consumer; one transaction in flight at a time.

Parameters:
- WIDTH, 8, operand width; power of two, >=4.
- CMD_WIDTH, 4, command field width.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- CE  in  1  clock enable; low freezes all state and outputs.
- IN_VLD  in  1  input transaction valid.
- IN_RDY  out  1  block can accept a transaction.
- OP_VALID  in  2  operand qualifiers: bit0=OPA valid, bit1=OPB valid.
- MODE  in  1  1=arithmetic, 0=logical.
- CMD  in  CMD_WIDTH  operation code.
- OPA, OPB  in  WIDTH  operands.
- CIN  in  1  carry/borrow in.
- RES  out  2*WIDTH  result.
- COUT, OFLOW, G, E, L, ERR  out  1 each  flags, registered with RES.
- OUT_VLD  out  1  result valid.
- OUT_RDY  in  1  consumer accepts result.

Behaviour:
- Reset: RST_N low → state IDLE, multiply counter 0, RES=0, all flags 0, OUT_VLD=0, IN_RDY=0. IN_RDY rises the first CE cycle after release.
- Reset mid-multiply aborts the operation; no OUT_VLD is produced.
- IN_RDY = CE && state!=MUL && (!OUT_VLD || OUT_RDY). Accept = IN_VLD && IN_RDY; all inputs are captured on the accept edge.
- OUT_VLD drops on the edge where OUT_RDY=1 and no new result lands. RES and flags hold stable while OUT_VLD=1 && OUT_RDY=0.
- Accept and drain in the same cycle → the new result replaces the old one; OUT_VLD stays 1.
- FSM:
  - IDLE: accept of a single-cycle op → result registered, OUT_VLD=1 next edge. Accept of a MUL op → MUL.
  - MUL: one partial-product step per CE cycle for WIDTH+1 cycles. On the last step, load RES, set OUT_VLD, go to IDLE.
  - MUL latency: OUT_VLD at edge WIDTH+2 after accept (10 for WIDTH=8).
- Every result clears all flags not listed for its op.
- Operand requirement:
  - Two-operand ops need OP_VALID=11; *_A ops need bit0; *_B ops need bit1.
  - Violation or undefined CMD → RES=0, ERR=1, other flags 0, still emitted as a normal 1-cycle result.
- MODE=1 commands (result zero-extended unless noted):
  - 0 ADD: RES=A+B (W+1 bits), COUT=bit W.
  - 1 SUB: RES=A-B, OFLOW=(A<B).
  - 2 ADDC: A+B+CIN, COUT=bit W.
  - 3 SUBC: A-B-CIN, OFLOW=borrow out of the (W+1)-bit difference.
  - 4 INC_A: COUT=carry out. 5 DEC_A: OFLOW=(A==0).
  - 6 INC_B, 7 DEC_B: same flag rules as INC_A/DEC_A.
  - 8 CMP: RES=0; exactly one of G/E/L set, unsigned compare.
  - 9 MUL_INC: (A+1)*(B+1). 10 MUL_SHL: (A<<1)*B, with A<<1 kept W+1 bits. Both: RES=low 2W bits, COUT=bit 2W.
  - 11 SADD: signed A+B, RES sign-extended from W bits; OFLOW=signed overflow; COUT=unsigned carry out.
  - 12 SSUB: signed A-B, RES sign-extended; OFLOW=signed overflow; COUT=0.
- MODE=0 commands (W-bit result, zero-extended):
  - 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR.
  - 6 NOT_A, 7 NOT_B.
  - 8 SHR1_A, 9 SHL1_A, 10 SHR1_B, 11 SHL1_B.
  - 12 ROL, 13 ROR: rotate A by OPB[$clog2(WIDTH)-1:0]; ERR=1 if OPB>=WIDTH, rotate still applied with the masked amount.
- CE low: no accept, MUL counter does not advance, OUT_VLD/RES hold. OUT_RDY is ignored while CE low.

Optional Feature:
- ALU_PARITY_EN defined: extra output RES_PAR (1 bit) = even parity (XOR reduction) of RES. Registered with RES, reset 0, holds under backpressure.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- WIDTH=8, MODE=1, CMD=0, OP_VALID=11, A=FF, B=01, OUT_RDY=1 → next edge: OUT_VLD=1, RES=0100, COUT=1, other flags 0.
- CMD=9, A=03, B=03 → IN_RDY low for 9 cycles, OUT_VLD at edge 10, RES=0010, COUT=0. Repeat with A=FF, B=FF → RES=0000, COUT=1.
- OUT_RDY=0; issue ADD 01+02, then XOR → XOR not accepted (IN_RDY=0), RES=0003 held. Raise OUT_RDY → XOR accepted that cycle, its result appears next edge.
- MODE=0, CMD=12, A=81, B=01 → RES=0003, ERR=0. With B=09 → RES=0003, ERR=1.
- MODE=1, CMD=0, OP_VALID=01 → RES=0, ERR=1. SSUB A=80, B=01 → RES=007F, OFLOW=1, COUT=0.
- RST_N low 4 cycles into a MUL → all outputs 0 asynchronously, no OUT_VLD afterwards, IN_RDY=1 the first cycle after release.
